// File: rtl/wbm_pkg.sv
// Shared types and constants for the Wishbone master bridge.
// Response status codes and bridge FSM state encoding.
package wbm_pkg;

    localparam logic [1:0] WBM_ST_OK      = 2'b00;
    localparam logic [1:0] WBM_ST_ERR     = 2'b01;
    localparam logic [1:0] WBM_ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wbm_state_e;

endpackage

// File: rtl/wbm_watchdog.sv
// Clear/enable cycle counter with terminal-count flag.
// Saturates at TIMEOUT so it never wraps back into range.
module wbm_watchdog
    import wbm_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TW'(TIMEOUT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone classic initiator: one command in, one single transfer,
// one response out, with a watchdog abort when the slave stays silent.
module wb_master_bridge
    import wbm_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_status,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i
);

    wbm_state_e          r_state;
    logic                r_cyc;
    logic                r_stb;
    logic                r_we;
    logic [ADDR_W-1:0]   r_adr;
    logic [DATA_W-1:0]   r_dat;
    logic [DATA_W/8-1:0] r_sel;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_status;

    logic w_accept;
    logic w_tick;
    logic w_tc;

    assign cmd_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    // Only silent BUS cycles count toward the abort.
    assign w_tick    = (r_state == ST_BUS) && !wbm_ack_i && !wbm_err_i;

    wbm_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_accept),
        .i_en  (w_tick),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_status    <= WBM_ST_OK;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we    <= cmd_we;
                        r_adr   <= cmd_addr;
                        r_dat   <= cmd_wdata;
                        r_sel   <= cmd_sel;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_state <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (wbm_err_i) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= '0;
                        r_status    <= WBM_ST_ERR;
                        r_state     <= ST_RESP;
                    end else if (wbm_ack_i) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= r_we ? '0 : wbm_dat_i;
                        r_status    <= WBM_ST_OK;
                        r_state     <= ST_RESP;
                    end else if (w_tc) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= '0;
                        r_status    <= WBM_ST_TIMEOUT;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wbm_cyc_o  = r_cyc;
    assign wbm_stb_o  = r_stb;
    assign wbm_we_o   = r_we;
    assign wbm_adr_o  = r_adr;
    assign wbm_dat_o  = r_dat;
    assign wbm_sel_o  = r_sel;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rdata;
    assign rsp_status = r_status;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: delayed-ack slave model, vector table,
// plus backpressure and reset-mid-transfer sequences.
module tb_wb_master_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    wb_master_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_sel    (cmd_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_status (rsp_status),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_err_i  (wbm_err_i)
    );

    always #5 clk = ~clk;

    // Slave: answers in the lat-th cycle of STB high, counter re-arms on STB low.
    int          sl_lat  = 1;
    logic        sl_errm = 1'b0;
    logic        sl_dead = 1'b0;
    int          sl_cnt  = 0;
    logic [31:0] mem [16] = '{default: 32'h0};
    logic        w_hit;
    logic [3:0]  w_idx;

    assign w_idx     = wbm_adr_o[5:2];
    assign w_hit     = wbm_stb_o && !sl_dead && (sl_cnt == sl_lat - 1);
    assign wbm_ack_i = w_hit;
    assign wbm_err_i = w_hit && sl_errm;
    assign wbm_dat_i = mem[w_idx];

    always @(posedge clk) begin
        if (wbm_stb_o && !w_hit) sl_cnt <= sl_cnt + 1;
        else sl_cnt <= 0;
        if (w_hit && !sl_errm && wbm_we_o) begin
            for (int b = 0; b < 4; b++)
                if (wbm_sel_o[b]) mem[w_idx][8*b +: 8] <= wbm_dat_o[8*b +: 8];
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          lat;
        logic        errm;
        logic        dead;
        logic [1:0]  st;
        logic [31:0] rd;
        int          cyc;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s,
                                input int lat, input logic em,
                                input logic dd, input logic [1:0] st,
                                input logic [31:0] rd, input int cyc);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.sel = s;
        v.lat = lat; v.errm = em; v.dead = dd;
        v.st = st; v.rd = rd; v.cyc = cyc;
        return v;
    endfunction

    task automatic issue(input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        int n;
        cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_sel = s;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int t);
        t = 1;
        while (!rsp_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rsp_valid) begin
            failures++;
            checks++;
            $display("FAIL rsp_wait: rsp_valid never rose within %0d", t);
        end
    endtask

    task automatic run_vec(input int i);
        int   t;
        int   ncyc;
        logic bad;
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        sl_lat = v.lat; sl_errm = v.errm; sl_dead = v.dead;
        rsp_ready = 1'b1;
        issue(v.we, v.addr, v.wdata, v.sel);
        t = 1; ncyc = 0; bad = 1'b0;
        while (!rsp_valid && t < 200) begin
            if (wbm_cyc_o) begin
                ncyc++;
                if (!wbm_stb_o || wbm_adr_o !== v.addr || wbm_we_o !== v.we ||
                    wbm_sel_o !== v.sel || (v.we && wbm_dat_o !== v.wdata))
                    bad = 1'b1;
            end
            @(negedge clk);
            t++;
        end
        $display("vec %0d: cyc=%0d t=%0d st=%0b rd=%08h", i, ncyc, t,
                 rsp_status, rsp_rdata);
        chk($sformatf("v%0d_valid", i), {63'd0, rsp_valid}, 64'd1);
        chk($sformatf("v%0d_status", i), {62'd0, rsp_status}, {62'd0, v.st});
        chk($sformatf("v%0d_rdata", i), {32'd0, rsp_rdata}, {32'd0, v.rd});
        chk($sformatf("v%0d_cyc_len", i), 64'(ncyc), 64'(v.cyc));
        chk($sformatf("v%0d_rsp_lat", i), 64'(t), 64'(v.cyc + 1));
        chk($sformatf("v%0d_bus_hold", i), {63'd0, bad}, 64'd0);
        chk($sformatf("v%0d_cyc_drop", i), {62'd0, wbm_cyc_o, wbm_stb_o}, 64'd0);
        @(negedge clk);
        chk($sformatf("v%0d_ready_back", i), {63'd0, cmd_ready}, 64'd1);
        chk($sformatf("v%0d_valid_clr", i), {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        int   t;
        logic bad;
        vecs[0]  = mk(1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 10, 0, 0, 2'b00, 32'h0, 10);
        vecs[1]  = mk(0, 32'h3800_0010, 32'h0,         4'hF, 10, 0, 0, 2'b00, 32'hDEAD_BEEF, 10);
        vecs[2]  = mk(1, 32'h3800_0020, 32'hFFFF_FFFF, 4'hF, 3,  0, 0, 2'b00, 32'h0, 3);
        vecs[3]  = mk(1, 32'h3800_0020, 32'h1234_5678, 4'h3, 3,  0, 0, 2'b00, 32'h0, 3);
        vecs[4]  = mk(0, 32'h3800_0020, 32'h0,         4'hF, 3,  0, 0, 2'b00, 32'hFFFF_5678, 3);
        vecs[5]  = mk(0, 32'h3800_0010, 32'h0,         4'hF, 5,  1, 0, 2'b01, 32'h0, 5);
        vecs[6]  = mk(1, 32'h3800_0030, 32'h0000_0011, 4'hF, 1,  1, 0, 2'b01, 32'h0, 1);
        vecs[7]  = mk(0, 32'h3800_0030, 32'h0,         4'hF, 1,  0, 0, 2'b00, 32'h0, 1);
        vecs[8]  = mk(0, 32'h3800_0010, 32'h0,         4'hF, 1,  0, 1, 2'b10, 32'h0, 64);
        vecs[9]  = mk(0, 32'h3800_0010, 32'h0,         4'hF, 64, 0, 0, 2'b00, 32'hDEAD_BEEF, 64);
        vecs[10] = mk(0, 32'h3800_0010, 32'h0,         4'hF, 65, 0, 0, 2'b10, 32'h0, 64);

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_status, rsp_rdata}, 64'd0);
        chk("rst_wbm", {28'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
                        wbm_adr_o[26:0]}, 64'd0);
        chk("rst_wbm_dat", {32'd0, wbm_dat_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, cmd_ready}, 64'd1);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Backpressure, then a back-to-back command straight after release.
        @(negedge clk);
        sl_lat = 2; sl_errm = 1'b0; sl_dead = 1'b0;
        rsp_ready = 1'b0;
        issue(1'b0, 32'h3800_0010, 32'h0, 4'hF);
        wait_rsp(t);
        cmd_we = 1'b0; cmd_addr = 32'h3800_0020; cmd_sel = 4'hF;
        cmd_valid = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!rsp_valid || rsp_rdata !== 32'hDEAD_BEEF ||
                rsp_status !== 2'b00 || cmd_ready || wbm_cyc_o)
                bad = 1'b1;
            @(negedge clk);
        end
        chk("bp_hold", {63'd0, bad}, 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_next", {63'd0, cmd_ready}, 64'd1);
        chk("bp_valid_clr", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_cyc", {63'd0, wbm_cyc_o}, 64'd1);
        chk("b2b_adr", {32'd0, wbm_adr_o}, 64'h3800_0020);
        wait_rsp(t);
        chk("b2b_rdata", {32'd0, rsp_rdata}, 64'hFFFF_5678);
        chk("b2b_lat", 64'(t), 64'd3);

        // Reset in the fifth BUS cycle of a 10-cycle read.
        @(negedge clk);
        sl_lat = 10;
        issue(1'b0, 32'h3800_0010, 32'h0, 4'hF);
        repeat (4) @(negedge clk);
        chk("mid_cyc_before", {63'd0, wbm_cyc_o}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_cyc_drop", {62'd0, wbm_cyc_o, wbm_stb_o}, 64'd0);
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (rsp_valid || wbm_cyc_o) bad = 1'b1;
            @(negedge clk);
        end
        chk("mid_no_rsp", {63'd0, bad}, 64'd0);
        run_vec(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
